dht11_receiver: RTL and testbench

Decodes the 40-bit DHT11 data frame that follows the sensor handshake. It sits directly downstream of the start-signal generator: that block's `confirm_to_reciver` pulse arms this receiver, which then times the high width of each bit on the sampled DHT11 data line. It shifts in 40 bits MSB-first, verifies the checksum, and presents humidity and temperature bytes with a one-cycle valid pulse.

---
 rtl/dht11_receiver.sv | 186 ++++++++++++++++++
 tb/tb_dht11_receiver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_receiver.sv
// DHT11 40-bit frame receiver: times each bit's high width on the synchronized
// data line, shifts bits in MSB-first, verifies the checksum and posts the bytes.
module dht11_receiver #(
  parameter int THRESH_CYCLES  = 40,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       data_in,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       valid,
  output logic       checksum_err,
  output logic       timeout,
  output logic       busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(THRESH_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, data_s_q, data_d_q;
  logic [39:0]      shreg_q, shreg_d;
  logic [5:0]       bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [7:0]       hum_int_q, hum_int_d;
  logic [7:0]       hum_dec_q, hum_dec_d;
  logic [7:0]       temp_int_q, temp_int_d;
  logic [7:0]       temp_dec_q, temp_dec_d;
  logic             valid_q, valid_d;
  logic             cerr_q, cerr_d;
  logic             tmo_q, tmo_d;

  logic fall, rise, timed_out;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic checksum_ok(input logic [39:0] f);
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return s == f[7:0];
  endfunction

  assign fall      = data_d_q & ~data_s_q;
  assign rise      = ~data_d_q & data_s_q;
  assign timed_out = (cyc_q == CNT_MAX);

  // Synchronizer resets high so an idle line never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      data_s_q <= 1'b1;
      data_d_q <= 1'b1;
    end else begin
      sync1_q  <= data_in;
      data_s_q <= sync1_q;
      data_d_q <= data_s_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    cyc_d      = cyc_q;
    hum_int_d  = hum_int_q;
    hum_dec_d  = hum_dec_q;
    temp_int_d = temp_int_q;
    temp_dec_d = temp_dec_q;
    valid_d    = 1'b0;
    cerr_d     = 1'b0;
    tmo_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ARM;
          shreg_d  = '0;
          bitcnt_d = '0;
          cyc_d    = '0;
        end
      end
      S_ARM: begin
        if (fall) begin
          state_d = S_BIT_LOW;
          cyc_d   = '0;
        end else if (timed_out) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          cyc_d = sat_inc(cyc_q);
        end
      end
      S_BIT_LOW: begin
        if (rise) begin
          state_d = S_BIT_HIGH;
          cyc_d   = CNT_W'(1);
        end else if (timed_out) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          cyc_d = sat_inc(cyc_q);
        end
      end
      S_BIT_HIGH: begin
        // The falling edge ends this bit and starts the next bit's low phase.
        if (fall) begin
          shreg_d  = {shreg_q[38:0], (cyc_q > THRESH)};
          bitcnt_d = bitcnt_q + 6'd1;
          cyc_d    = '0;
          state_d  = (bitcnt_q == 6'd39) ? S_CHECK : S_BIT_LOW;
        end else if (timed_out) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else if (data_s_q) begin
          cyc_d = sat_inc(cyc_q);
        end
      end
      S_CHECK: begin
        if (checksum_ok(shreg_q)) begin
          hum_int_d  = shreg_q[39:32];
          hum_dec_d  = shreg_q[31:24];
          temp_int_d = shreg_q[23:16];
          temp_dec_d = shreg_q[15:8];
          valid_d    = 1'b1;
        end else begin
          cerr_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      cyc_q      <= '0;
      hum_int_q  <= '0;
      hum_dec_q  <= '0;
      temp_int_q <= '0;
      temp_dec_q <= '0;
      valid_q    <= 1'b0;
      cerr_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      cyc_q      <= cyc_d;
      hum_int_q  <= hum_int_d;
      hum_dec_q  <= hum_dec_d;
      temp_int_q <= temp_int_d;
      temp_dec_q <= temp_dec_d;
      valid_q    <= valid_d;
      cerr_q     <= cerr_d;
      tmo_q      <= tmo_d;
    end
  end

  assign hum_int      = hum_int_q;
  assign hum_dec      = hum_dec_q;
  assign temp_int     = temp_int_q;
  assign temp_dec     = temp_dec_q;
  assign valid        = valid_q;
  assign checksum_err = cerr_q;
  assign timeout      = tmo_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_dht11_receiver.sv
// Directed/randomized bench for dht11_receiver: drives DHT11 bit waveforms and
// compares decoded bytes and status pulses against a width-based frame model.
`timescale 1ns/1ps
module tb_dht11_receiver;

  localparam int THRESH = 40;
  localparam int TMO    = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       data_in = 1'b1;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
  logic       valid, checksum_err, timeout, busy;

  dht11_receiver #(.THRESH_CYCLES(THRESH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .valid(valid), .checksum_err(checksum_err), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int passed = 0, checks = 0, n_fail = 0;

  // Event monitor, sampled on the falling edge.
  int   cyc_num = 0;
  int   cnt_valid = 0, cnt_cerr = 0, cnt_tmo = 0;
  int   cnt_multi = 0, cnt_busy_pulse = 0, cnt_long = 0, tmo_cycle = 0;
  logic prev_pulse = 1'b0;

  always @(posedge clk) cyc_num <= cyc_num + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid)        cnt_valid <= cnt_valid + 1;
      if (checksum_err) cnt_cerr  <= cnt_cerr + 1;
      if (timeout) begin
        cnt_tmo   <= cnt_tmo + 1;
        tmo_cycle <= cyc_num;
      end
      if ((int'(valid) + int'(checksum_err) + int'(timeout)) > 1) cnt_multi <= cnt_multi + 1;
      if ((valid | checksum_err | timeout) && busy) cnt_busy_pulse <= cnt_busy_pulse + 1;
      if ((valid | checksum_err | timeout) && prev_pulse) cnt_long <= cnt_long + 1;
      prev_pulse <= valid | checksum_err | timeout;
    end else begin
      prev_pulse <= 1'b0;
    end
  end

  int         hi_w[40];
  int         lo_w[40];
  logic [31:0] exp_data = 32'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Assign high/low widths for each bit of a 40-bit frame (MSB first).
  task automatic set_widths(input logic [39:0] bits, input int w0, input int w1, input bit rnd);
    for (int i = 0; i < 40; i++) begin
      if (rnd) begin
        hi_w[i] = bits[39-i] ? int'($urandom_range(45, 75)) : int'($urandom_range(20, 35));
        lo_w[i] = int'($urandom_range(45, 55));
      end else begin
        hi_w[i] = bits[39-i] ? w1 : w0;
        lo_w[i] = 50;
      end
    end
  endtask

  // Drive the bit waveforms; stop_at ends early (optionally holding the line low).
  task automatic drive_frame(input int restart_at, input int stop_at, input bit stuck_low);
    for (int i = 0; i < 40; i++) begin
      if (i == stop_at) begin
        if (stuck_low) begin
          data_in = 1'b0;
          tick(300);
          data_in = 1'b1;
          tick(5);
        end
        return;
      end
      data_in = 1'b0;
      if (i == restart_at) begin
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(lo_w[i] - 1);
      end else begin
        tick(lo_w[i]);
      end
      data_in = 1'b1;
      tick(hi_w[i]);
    end
    data_in = 1'b0;
    tick(50);
    data_in = 1'b1;
    tick(10);
  endtask

  // Reference model: a bit is 1 when its high width exceeds the threshold.
  function automatic logic [39:0] model_bits();
    logic [39:0] v;
    v = '0;
    for (int i = 0; i < 40; i++) v[39-i] = (hi_w[i] > THRESH);
    return v;
  endfunction

  task automatic run_frame(input string tag, input int restart_at);
    int cv, cc, ct, s;
    logic [39:0] f;
    bit ok;
    cv = cnt_valid; cc = cnt_cerr; ct = cnt_tmo;
    check({tag, "_idle_busy"}, busy, 0);
    pulse_start();
    check({tag, "_arm_busy"}, busy, 1);
    tick(3);
    drive_frame(restart_at, 99, 1'b0);
    f  = model_bits();
    s  = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    ok = ((s % 256) == int'(f[7:0]));
    if (ok) exp_data = f[39:8];
    check({tag, "_valid"}, cnt_valid - cv, ok ? 1 : 0);
    check({tag, "_cerr"},  cnt_cerr - cc,  ok ? 0 : 1);
    check({tag, "_tmo"},   cnt_tmo - ct,   0);
    check({tag, "_data"},  {hum_int, hum_dec, temp_int, temp_dec}, exp_data);
    check({tag, "_busy"},  busy, 0);
  endtask

  task automatic run_timeout(input string tag, input bit in_arm);
    int cv, cc, ct, t0;
    cv = cnt_valid; cc = cnt_cerr; ct = cnt_tmo;
    pulse_start();
    t0 = cyc_num;
    if (in_arm) begin
      tick(300);
      check({tag, "_latency_ok"}, ((tmo_cycle - t0) >= 199 && (tmo_cycle - t0) <= 203), 1);
    end else begin
      tick(3);
      drive_frame(-1, 5, 1'b1);
    end
    check({tag, "_tmo"},   cnt_tmo - ct,   1);
    check({tag, "_valid"}, cnt_valid - cv, 0);
    check({tag, "_cerr"},  cnt_cerr - cc,  0);
    check({tag, "_data"},  {hum_int, hum_dec, temp_int, temp_dec}, exp_data);
    check({tag, "_busy"},  busy, 0);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  ck;
    int          cv, cc, ct;

    // Reset state
    tick(3);
    check("rst_data",   {hum_int, hum_dec, temp_int, temp_dec}, 32'h0);
    check("rst_status", {valid, checksum_err, timeout, busy}, 4'b0000);
    rst = 1'b0;
    tick(5);

    // Reference good frame
    set_widths({8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, 26, 70, 1'b0);
    run_frame("good", -1);
    check("good_const", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37001900);

    // Bad checksum retains previous frame
    set_widths({8'h37, 8'h00, 8'h19, 8'h00, 8'h51}, 26, 70, 1'b0);
    run_frame("badck", -1);
    check("badck_const", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37001900);

    // Threshold boundary: 40 -> 0, 41 -> 1
    set_widths({32'h55555555, 8'h54}, 40, 41, 1'b0);
    run_frame("thr_a", -1);
    check("thr_a_const", {hum_int, hum_dec, temp_int, temp_dec}, 32'h55555555);
    set_widths({32'hAAAAAAAA, 8'hA8}, 40, 41, 1'b0);
    run_frame("thr_b", -1);
    check("thr_b_const", {hum_int, hum_dec, temp_int, temp_dec}, 32'hAAAAAAAA);

    // Randomized frames (good checksum)
    for (int k = 0; k < 3; k++) begin
      r  = $urandom;
      ck = r[31:24] + r[23:16] + r[15:8] + r[7:0];
      set_widths({r, ck}, 0, 0, 1'b1);
      run_frame("rand", -1);
    end

    // Randomized frame with corrupted checksum
    r  = $urandom;
    ck = r[31:24] + r[23:16] + r[15:8] + r[7:0] + 8'(int'($urandom_range(1, 255)));
    set_widths({r, ck}, 0, 0, 1'b1);
    run_frame("rand_bad", -1);

    // Timeouts: line idle high in ARM, then stuck low mid-frame
    run_timeout("tmo_arm", 1'b1);
    run_timeout("tmo_low", 1'b0);

    // Asynchronous reset mid-frame
    cv = cnt_valid; cc = cnt_cerr; ct = cnt_tmo;
    r  = $urandom;
    ck = r[31:24] + r[23:16] + r[15:8] + r[7:0];
    set_widths({r, ck}, 0, 0, 1'b1);
    pulse_start();
    tick(3);
    drive_frame(-1, 21, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_data",   {hum_int, hum_dec, temp_int, temp_dec}, 32'h0);
    check("midrst_status", {valid, checksum_err, timeout, busy}, 4'b0000);
    exp_data = 32'h0;
    data_in  = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);
    check("midrst_nopulse", (cnt_valid - cv) + (cnt_cerr - cc) + (cnt_tmo - ct), 0);
    set_widths({8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, 26, 70, 1'b0);
    run_frame("after_rst", -1);

    // Start pulse during busy is ignored
    r  = $urandom;
    ck = r[31:24] + r[23:16] + r[15:8] + r[7:0];
    set_widths({r, ck}, 0, 0, 1'b1);
    run_frame("restart", 10);

    // Pulse properties over the whole run
    check("pulse_exclusive", cnt_multi, 0);
    check("pulse_busy_low",  cnt_busy_pulse, 0);
    check("pulse_one_cycle", cnt_long, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
